// File: rtl/rr_mux_stage.sv
// Single-stage N:1 multiplexer with a registered output and ready/valid handshakes on both sides.
// Source selection is either a fixed index or a rotating round-robin priority search.
module rr_mux_stage #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  localparam int SW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SW-1:0]        sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_chan,
  input  logic                 out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_chan_q, out_chan_d;
  logic [SW-1:0]    ptr_q, ptr_d;

  logic             load;
  logic             grant_vld;
  logic [SW-1:0]    grant_idx;

  assign load = ~out_valid_q | out_ready;

  // Grant selection; round-robin scans ptr, ptr+1, ... wrapping at NCH-1.
  always_comb begin
    int            c;
    logic [SW-1:0] cidx;
    grant_vld = 1'b0;
    grant_idx = '0;
    c         = 0;
    cidx      = '0;
    if (!mode) begin
      if (int'(sel) < NCH) begin
        grant_vld = in_valid[sel];
        grant_idx = sel;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        c = int'(ptr_q) + k;
        if (c >= NCH) c = c - NCH;
        cidx = SW'(c);
        if (!grant_vld && in_valid[cidx]) begin
          grant_vld = 1'b1;
          grant_idx = cidx;
        end
      end
    end
  end

  // in_ready is held low during reset even though load would be high.
  always_comb begin
    in_ready = '0;
    if (grant_vld && load && rst_n) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_chan_d  = grant_idx;
        if (mode) ptr_d = (int'(grant_idx) == NCH - 1) ? '0 : SW'(int'(grant_idx) + 1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_mux_stage.sv
// Directed table-driven bench for rr_mux_stage at WIDTH=8, NCH=4.
// Channel data is fixed: ch0=11, ch1=22, ch2=A5, ch3=3C.
module tb_rr_mux_stage;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_ready;

  int total;
  int bad;

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic [1:0] exp_oc;
  } vec_t;

  vec_t vecs[21];
  vec_t post[4];

  rr_mux_stage #(.WIDTH(8), .NCH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic m, logic [1:0] s, logic [3:0] iv, logic ordy,
                              logic [3:0] rdy, logic ov, logic [7:0] od, logic [1:0] oc);
    vec_t v;
    v.mode = m; v.sel = s; v.iv = iv; v.ordy = ordy;
    v.exp_rdy = rdy; v.exp_ov = ov; v.exp_od = od; v.exp_oc = oc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive at negedge, check in_ready before the edge, check registered outputs after it.
  task automatic apply(vec_t v, string tag);
    @(negedge clk);
    mode = v.mode; sel = v.sel; in_valid = v.iv; out_ready = v.ordy;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_ov));
    chk({tag, " out_data"}, 32'(out_data), 32'(v.exp_od));
    chk({tag, " out_chan"}, 32'(out_chan), 32'(v.exp_oc));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //              mode sel  in_valid ordy  in_ready  ov  data   chan
    vecs[0]  = mk(0, 2'd2, 4'b1111, 1, 4'b0100, 1, 8'hA5, 2'd2); // fixed select
    vecs[1]  = mk(1, 2'd0, 4'b1111, 1, 4'b0001, 1, 8'h11, 2'd0); // rr fairness 0..3,0
    vecs[2]  = mk(1, 2'd0, 4'b1111, 1, 4'b0010, 1, 8'h22, 2'd1);
    vecs[3]  = mk(1, 2'd0, 4'b1111, 1, 4'b0100, 1, 8'hA5, 2'd2);
    vecs[4]  = mk(1, 2'd0, 4'b1111, 1, 4'b1000, 1, 8'h3C, 2'd3);
    vecs[5]  = mk(1, 2'd0, 4'b1111, 1, 4'b0001, 1, 8'h11, 2'd0);
    vecs[6]  = mk(1, 2'd0, 4'b0100, 1, 4'b0100, 1, 8'hA5, 2'd2); // ptr -> 3
    vecs[7]  = mk(1, 2'd0, 4'b0011, 1, 4'b0001, 1, 8'h11, 2'd0); // wrap/skip to ch0
    vecs[8]  = mk(1, 2'd0, 4'b0011, 1, 4'b0010, 1, 8'h22, 2'd1);
    vecs[9]  = mk(0, 2'd3, 4'b0111, 1, 4'b0000, 0, 8'h22, 2'd1); // fixed sel not valid
    vecs[10] = mk(1, 2'd0, 4'b0000, 1, 4'b0000, 0, 8'h22, 2'd1);
    vecs[11] = mk(1, 2'd0, 4'b1001, 1, 4'b1000, 1, 8'h3C, 2'd3); // ptr=2 skips to ch3
    vecs[12] = mk(1, 2'd0, 4'b1111, 0, 4'b0000, 1, 8'h3C, 2'd3); // backpressure x3
    vecs[13] = mk(0, 2'd0, 4'b1111, 0, 4'b0000, 1, 8'h3C, 2'd3);
    vecs[14] = mk(1, 2'd0, 4'b1111, 0, 4'b0000, 1, 8'h3C, 2'd3);
    vecs[15] = mk(1, 2'd0, 4'b1111, 1, 4'b0001, 1, 8'h11, 2'd0); // release loads same edge
    vecs[16] = mk(1, 2'd0, 4'b0000, 1, 4'b0000, 0, 8'h11, 2'd0); // idle drain
    vecs[17] = mk(0, 2'd1, 4'b0010, 0, 4'b0010, 1, 8'h22, 2'd1); // empty stage ignores ordy
    vecs[18] = mk(1, 2'd0, 4'b1111, 0, 4'b0000, 1, 8'h22, 2'd1);
    vecs[19] = mk(1, 2'd0, 4'b1111, 1, 4'b0010, 1, 8'h22, 2'd1); // mode0 left ptr at 1
    vecs[20] = mk(1, 2'd0, 4'b1111, 1, 4'b0100, 1, 8'hA5, 2'd2);

    post[0]  = mk(1, 2'd0, 4'b1010, 1, 4'b0010, 1, 8'h22, 2'd1); // ptr restarted at 0
    post[1]  = mk(1, 2'd0, 4'b1000, 1, 4'b1000, 1, 8'h3C, 2'd3);
    post[2]  = mk(1, 2'd0, 4'b1111, 1, 4'b0001, 1, 8'h11, 2'd0); // ptr wrapped 3 -> 0
    post[3]  = mk(1, 2'd0, 4'b0000, 1, 4'b0000, 0, 8'h11, 2'd0);

    in_data   = 32'h3CA52211;
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #2;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_chan", 32'(out_chan), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("reset held out_valid", 32'(out_valid), 32'd0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 21; i++) apply(vecs[i], $sformatf("v%0d", i));

    // Async reset mid-cycle with a valid word held
    @(negedge clk);
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    #2;
    chk("pre-reset out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async out_data", 32'(out_data), 32'd0);
    chk("async out_chan", 32'(out_chan), 32'd0);
    chk("async in_ready", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 4; i++) apply(post[i], $sformatf("p%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rr_mux_stage.md
RR_MUX_STAGE -- requirements
Module: rr_mux_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel.
REQ-002 SHALL have parameter NCH, default 4, number of input channels, legal range 2..16.
REQ-003 SHALL define SW = max(1, clog2(NCH)) as a derived local width, not overridable.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  NCH  per-channel request; bit i belongs to channel i.
REQ-007 SHALL have port in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port in_ready  output  NCH  per-channel accept, one-hot or zero.
REQ-009 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 SHALL have port sel  input  SW  channel index used when mode=0.
REQ-011 SHALL have port out_valid  output  1  registered output holds a word.
REQ-012 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-013 SHALL have port out_chan  output  SW  registered index of the source channel.
REQ-014 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-015 SHALL compute load = ~out_valid | out_ready each cycle, combinationally.
REQ-016 SHALL, mode=0: grant channel sel iff in_valid[sel]=1 and sel<NCH; otherwise no grant.
REQ-017 SHALL, mode=1: grant first channel with in_valid=1 searching ptr, ptr+1, ... NCH-1, 0, ... ptr-1 (wrap); no grant if in_valid=0.
REQ-018 SHALL drive in_ready[g]=load for granted channel g, 0 for all others; in_ready never depends on in_valid of a non-granted channel.
REQ-019 SHALL define a transfer on channel g as in_valid[g] & in_ready[g] at a rising edge.
REQ-020 SHALL, on transfer, register out_data<=in_data[g], out_chan<=g, out_valid<=1 (latency 1 cycle, throughput 1 word/cycle).
REQ-021 SHALL, when load=1 and no grant, clear out_valid to 0; out_data and out_chan hold.
REQ-022 SHALL, when load=0 (out_valid=1, out_ready=0), hold out_valid, out_data, out_chan unchanged; all in_ready=0.
REQ-023 SHALL update ptr<=(g+1) mod NCH only on a mode=1 transfer; ptr holds otherwise, including all mode=0 cycles.
REQ-024 SHALL apply mode and sel changes to the next arbitration with no pipeline flush; a held output word is unaffected.
REQ-025 SHALL keep ptr in 0..NCH-1 for non-power-of-2 NCH (wrap at NCH-1 -> 0).
REQ-026 SHALL never drop or duplicate a word: each transfer produces exactly one out_valid&out_ready handshake.

Reset
REQ-027 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_chan=0, ptr=0 immediately, independent of clk.
REQ-028 SHALL drive all in_ready=0 while rst_n=0.
REQ-029 SHALL, on reset assertion mid-transfer, discard the held word; first post-reset grant in mode=1 starts search at channel 0.
REQ-030 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Verification (WIDTH=8, NCH=4)
REQ-031 SHALL cover fixed select: mode=0, sel=2, in_valid=4'b1111, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_chan=2.
REQ-032 SHALL cover round-robin fairness: mode=1, in_valid=4'b1111 held, out_ready=1 from reset -> out_chan sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 SHALL cover wrap and skip: mode=1, ptr=3, in_valid=4'b0011 -> grant ch0, ptr becomes 1; next grant ch1, ptr becomes 2.
REQ-034 SHALL cover backpressure: out_valid=1 holding 8'h3C, out_ready=0 for 3 cycles -> out_data stays 8'h3C, in_ready=4'b0000 all 3 cycles; out_ready=1 -> new word loaded same edge.
REQ-035 SHALL cover idle drain: out_valid=1, out_ready=1, in_valid=0 -> next cycle out_valid=0, out_data unchanged.
REQ-036 SHALL cover async reset: rst_n low mid-cycle with out_valid=1 -> out_valid=0, out_data=0 before next clk edge; after release, mode=1, in_valid=4'b1000 -> grant ch3, ptr becomes 0.
